// File: rtl/md_ctrl_if.sv
// EX-stage <-> multiply/divide controller signal bundle.
// master: pipeline side driving requests; slave: md_ctrl.
interface md_ctrl_if;
  logic        OpValid;
  logic [1:0]  Op;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        MtValid;
  logic        MfValid;
  logic        HiSel;
  logic        Hold;
  logic        Flush;

  logic        MdStart;
  logic [1:0]  MdOp;
  logic [31:0] MdD1;
  logic [31:0] MdD2;
  logic        MdWe;
  logic        MdHiLo;
  logic        Stall;
  logic        MdDone;
  logic        DivZero;

  modport master (
    output OpValid, Op, RsData, RtData, MtValid, MfValid, HiSel, Hold, Flush,
    input  MdStart, MdOp, MdD1, MdD2, MdWe, MdHiLo, Stall, MdDone, DivZero
  );

  modport slave (
    input  OpValid, Op, RsData, RtData, MtValid, MfValid, HiSel, Hold, Flush,
    output MdStart, MdOp, MdD1, MdD2, MdWe, MdHiLo, Stall, MdDone, DivZero
  );
endinterface

// File: rtl/md_ctrl.sv
// Sequencing controller for the mul/div unit: issues starts and HI/LO writes,
// counts fixed op latency and stalls dependent mul/div/mt/mf instructions.
module md_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic     Clk,
  input  logic     Rst_n,
  md_ctrl_if.slave md
);

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
  localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       div_zero_q, div_zero_d;

  logic       accept;
  logic       start;
  logic       we;
  logic       stall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    start      = 1'b0;
    we         = 1'b0;
    stall      = 1'b0;
    accept     = (state_q == IDLE) && md.OpValid && !md.Hold && !md.Flush;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // A divide by zero is dropped here so HI/LO keep their contents.
          if (md.Op[1] && (md.RtData == '0)) begin
            div_zero_d = 1'b1;
          end else begin
            start   = 1'b1;
            cnt_d   = md.Op[1] ? DIV_CNT : MUL_CNT;
            state_d = BUSY;
          end
        end else if (md.MtValid && !md.OpValid && !md.Hold && !md.Flush) begin
          we = 1'b1;
        end
      end
      BUSY: begin
        // Hold and Flush are ignored: the unit cannot pause or abort.
        stall = md.OpValid || md.MtValid || md.MfValid;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign md.MdStart = Rst_n && start;
  assign md.MdWe    = Rst_n && we;
  assign md.Stall   = Rst_n && stall;
  assign md.MdOp    = Rst_n ? md.Op     : '0;
  assign md.MdD1    = Rst_n ? md.RsData : '0;
  assign md.MdD2    = Rst_n ? md.RtData : '0;
  assign md.MdHiLo  = Rst_n && md.HiSel;
  assign md.MdDone  = done_q;
  assign md.DivZero = div_zero_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: per-cycle expectations are queued when
// stimulus is driven and compared by a negedge monitor.
module tb_md_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  md_ctrl_if bus ();

  md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .md    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        start;
    logic        we;
    logic        stall;
    logic        done;
    logic        dz;
    logic        chk_data;
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        hilo;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".MdStart"}, 32'(bus.MdStart), 32'(e.start));
      check({e.tag, ".MdWe"},    32'(bus.MdWe),    32'(e.we));
      check({e.tag, ".Stall"},   32'(bus.Stall),   32'(e.stall));
      check({e.tag, ".MdDone"},  32'(bus.MdDone),  32'(e.done));
      check({e.tag, ".DivZero"}, 32'(bus.DivZero), 32'(e.dz));
      if (e.chk_data) begin
        check({e.tag, ".MdOp"},   32'(bus.MdOp),   32'(e.op));
        check({e.tag, ".MdD1"},   bus.MdD1,        e.d1);
        check({e.tag, ".MdD2"},   bus.MdD2,        e.d2);
        check({e.tag, ".MdHiLo"}, 32'(bus.MdHiLo), 32'(e.hilo));
      end
    end
  end

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic expect_cyc(input string tag, input logic start, input logic we,
                            input logic stall, input logic done, input logic dz,
                            input logic chk = 1'b0, input logic [1:0] op = 2'b00,
                            input logic [31:0] d1 = '0, input logic [31:0] d2 = '0,
                            input logic hilo = 1'b0);
    exp_t e;
    e.tag = tag; e.start = start; e.we = we; e.stall = stall; e.done = done; e.dz = dz;
    e.chk_data = chk; e.op = op; e.d1 = d1; e.d2 = d2; e.hilo = hilo;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.OpValid = 1'b0; bus.Op = 2'b00; bus.RsData = '0; bus.RtData = '0;
    bus.MtValid = 1'b0; bus.MfValid = 1'b0; bus.HiSel = 1'b0;
    bus.Hold = 1'b0; bus.Flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".MdStart"}, 32'(bus.MdStart), 32'd0);
    check({tag, ".MdWe"},    32'(bus.MdWe),    32'd0);
    check({tag, ".Stall"},   32'(bus.Stall),   32'd0);
    check({tag, ".MdDone"},  32'(bus.MdDone),  32'd0);
    check({tag, ".DivZero"}, 32'(bus.DivZero), 32'd0);
    check({tag, ".MdOp"},    32'(bus.MdOp),    32'd0);
    check({tag, ".MdD1"},    bus.MdD1,         32'd0);
    check({tag, ".MdD2"},    bus.MdD2,         32'd0);
    check({tag, ".MdHiLo"},  32'(bus.MdHiLo),  32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset with every request active: all outputs must still read 0.
    rst_n = 1'b0;
    idle_in();
    bus.OpValid = 1'b1; bus.Op = 2'b11; bus.RsData = 32'd5; bus.RtData = 32'd9;
    bus.MtValid = 1'b1; bus.MfValid = 1'b1; bus.HiSel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    idle_in();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) expect_cyc("idle", 0, 0, 0, 0, 0);

    // mult -3 * 7 followed by a waiting mflo.
    bus.OpValid = 1'b1; bus.Op = 2'b01; bus.RsData = 32'hFFFF_FFFD; bus.RtData = 32'd7;
    expect_cyc("mul_issue", 1, 0, 0, 0, 0, 1, 2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    idle_in();
    bus.MfValid = 1'b1;
    for (int i = 1; i <= 5; i++) expect_cyc("mul_busy", 0, 0, 1, 0, 0);
    expect_cyc("mul_done", 0, 0, 0, 1, 0);
    bus.MfValid = 1'b0;
    expect_cyc("mul_after", 0, 0, 0, 0, 0);

    // Back-to-back divu; second op held until the first completes.
    bus.OpValid = 1'b1; bus.Op = 2'b10; bus.RsData = 32'd100; bus.RtData = 32'd7;
    expect_cyc("divu1_issue", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) expect_cyc("divu1_busy", 0, 0, 1, 0, 0);
    expect_cyc("divu2_issue", 1, 0, 0, 1, 0);
    // Second divu in flight: a waiting mthi under Hold/Flush must not freeze it.
    bus.OpValid = 1'b0; bus.MtValid = 1'b1; bus.HiSel = 1'b1; bus.RsData = 32'h55;
    for (int unsigned i = 0; i < 10; i++) begin
      bus.Hold  = i[0];
      bus.Flush = (i == 3);
      expect_cyc("divu2_busy", 0, 0, 1, 0, 0);
    end
    bus.Hold = 1'b0; bus.Flush = 1'b0;
    expect_cyc("divu2_done_mt", 0, 1, 0, 1, 0, 1, 2'b10, 32'h55, 32'd7, 1);
    idle_in();
    expect_cyc("divu_after", 0, 0, 0, 0, 0);

    // Divide by zero is dropped; state stays IDLE so mthi issues immediately.
    bus.OpValid = 1'b1; bus.Op = 2'b11; bus.RsData = 32'd9; bus.RtData = 32'd0;
    expect_cyc("dz_issue", 0, 0, 0, 0, 0);
    bus.OpValid = 1'b0; bus.MtValid = 1'b1; bus.HiSel = 1'b1; bus.RsData = 32'hAA;
    expect_cyc("dz_mthi", 0, 1, 0, 0, 1, 1, 2'b11, 32'hAA, 32'd0, 1);
    idle_in();
    expect_cyc("dz_after", 0, 0, 0, 0, 0);

    // mtlo under Hold, then released, then Flushed.
    bus.MtValid = 1'b1; bus.HiSel = 1'b0; bus.RsData = 32'h1234; bus.Hold = 1'b1;
    expect_cyc("mtlo_hold", 0, 0, 0, 0, 0);
    bus.Hold = 1'b0;
    expect_cyc("mtlo_go", 0, 1, 0, 0, 0, 1, 2'b00, 32'h1234, 32'd0, 0);
    bus.Flush = 1'b1;
    expect_cyc("mtlo_flush", 0, 0, 0, 0, 0);
    // Op gated by Hold or Flush is not accepted.
    idle_in();
    bus.OpValid = 1'b1; bus.Op = 2'b01; bus.RtData = 32'd3; bus.Hold = 1'b1;
    expect_cyc("op_hold", 0, 0, 0, 0, 0);
    bus.Hold = 1'b0; bus.Flush = 1'b1;
    expect_cyc("op_flush", 0, 0, 0, 0, 0);
    // Op and Mt together: only the start issues.
    bus.Flush = 1'b0; bus.Op = 2'b00; bus.MtValid = 1'b1;
    expect_cyc("op_and_mt", 1, 0, 0, 0, 0);
    idle_in();
    for (int i = 1; i <= 5; i++) expect_cyc("multu_busy_quiet", 0, 0, 0, 0, 0);
    expect_cyc("multu_done", 0, 0, 0, 1, 0);

    // Asynchronous reset in cycle 3 of a div.
    bus.OpValid = 1'b1; bus.Op = 2'b11; bus.RsData = 32'd50; bus.RtData = 32'd5;
    expect_cyc("rdiv_issue", 1, 0, 0, 0, 0);
    idle_in();
    bus.MfValid = 1'b1;
    expect_cyc("rdiv_busy1", 0, 0, 1, 0, 0);
    expect_cyc("rdiv_busy2", 0, 0, 1, 0, 0);
    check("rdiv_pre_rst.Stall", 32'(bus.Stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rdiv_in_rst.Stall", 32'(bus.Stall), 32'd0);
    @(posedge clk);
    #1;
    check_all_zero("rdiv_rst_hold");
    rst_n = 1'b1;
    bus.MfValid = 1'b0;
    bus.OpValid = 1'b1; bus.Op = 2'b01; bus.RsData = 32'd4; bus.RtData = 32'd2;
    expect_cyc("rst_new_mult", 1, 0, 0, 0, 0, 1, 2'b01, 32'd4, 32'd2, 0);
    idle_in();
    bus.MfValid = 1'b1;
    for (int i = 1; i <= 5; i++) expect_cyc("rst_mult_busy", 0, 0, 1, 0, 0);
    expect_cyc("rst_mult_done", 0, 0, 0, 1, 0);
    idle_in();
    for (int i = 0; i < 6; i++) expect_cyc("rst_no_stale_done", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the pipeline's multiply/divide unit. It sits between the EX stage and the mul/div unit. It issues operation starts and HI/LO writes to the unit, and tracks each operation's fixed latency with an internal counter. It stalls the pipeline while a later multiply/divide, HI/LO move-to or HI/LO move-from instruction would observe an unfinished result.

## Interface
Parameters:
- MUL_LAT, 5: busy cycles after a mult/multu start; legal range 1..31.
- DIV_LAT, 10: busy cycles after a div/divu start; legal range 1..31.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- OpValid  in  1  EX instruction is mult/multu/div/divu.
- Op  in  2  operation code: 00 multu, 01 mult, 10 divu, 11 div.
- RsData  in  32  rs operand.
- RtData  in  32  rt operand.
- MtValid  in  1  EX instruction is mthi/mtlo.
- MfValid  in  1  EX instruction is mfhi/mflo.
- HiSel  in  1  for MtValid: 1 = HI, 0 = LO.
- Hold  in  1  pipeline frozen by another source; no new issue this cycle.
- Flush  in  1  EX instruction is cancelled this cycle.
- MdStart  out  1  start pulse to the unit.
- MdOp  out  2  operation code to the unit.
- MdD1  out  32  first operand to the unit.
- MdD2  out  32  second operand to the unit.
- MdWe  out  1  HI/LO write enable to the unit.
- MdHiLo  out  1  HI/LO select to the unit.
- Stall  out  1  freeze IF/ID/EX this cycle.
- MdDone  out  1  one-cycle pulse when an operation's result becomes readable.
- DivZero  out  1  one-cycle pulse when a divide by zero is dropped.

## Operation
State machine:
- States are IDLE and BUSY. Counter cnt is 5 bits.
- Reset: IDLE, cnt=0. MdStart, MdWe, MdDone, DivZero and Stall are all 0. MdOp, MdD1, MdD2 and MdHiLo are 0.

Issue and write paths (MdStart, MdWe, Stall are combinational):
- Operand wiring: MdD1=RsData, MdD2=RtData, MdOp=Op, MdHiLo=HiSel at all times except during reset.
- Accept condition: state==IDLE, OpValid=1, Hold=0, Flush=0.
  - If Op[1]=1 and RtData==0: MdStart=0, state stays IDLE, DivZero=1 in the next cycle. The HI/LO contents stay unchanged.
  - Otherwise: MdStart=1. At the edge, cnt loads MUL_LAT (Op[1]=0) or DIV_LAT (Op[1]=1) and state goes to BUSY.
- Move-to: MdWe=1 when state==IDLE, MtValid=1, Hold=0, Flush=0 and OpValid=0.
- Stall=1 when state==BUSY and any of OpValid, MtValid or MfValid is 1. It is independent of Hold and Flush.

BUSY sequencing:
- cnt decrements each cycle.
- At the edge where cnt==1, state goes to IDLE and MdDone=1 in the following cycle.

Priority and boundary rules:
- Priority is Op > Mt > Mf. If OpValid and MtValid are both 1, only the start is issued. That case is illegal stimulus, but the behaviour is defined.
- Flush during BUSY does not abort the operation, because the unit has no abort; it completes and MdDone still pulses.
- Hold during BUSY does not freeze cnt.
- Rst_n low at any point, including mid-BUSY, forces the reset state immediately. The operation in flight is abandoned and no MdDone is produced.

## Timing
- Accept in cycle k (MdStart=1). The unit is busy in cycles k+1..k+LAT.
- Stall can be 1 only in cycles k+1..k+LAT. The cycle k+LAT+1 is IDLE, and MdDone=1 in that cycle.
- An mfhi/mflo waiting in EX proceeds in cycle k+LAT+1. A new op in cycle k+LAT+1 is accepted in that same cycle, so there is no bubble between back-to-back operations.
- mf/mt issued in cycle k+1 with no new op: Stall=1 for exactly LAT cycles.
- DivZero pulse: cycle k+1, with no BUSY cycles.
- Latency from MdStart to result readable is LAT+1 cycles.

## Test plan
- Reset: Rst_n=0 -> all outputs 0. Release, then idle 3 cycles -> Stall=0, MdDone=0.
- mult followed by mflo:
  - Stimulus: Op=01, RsData=-3, RtData=7 in cycle 0, then MfValid=1 from cycle 1.
  - Required response: MdStart=1 only in cycle 0. Stall=1 in cycles 1..5, 0 in cycle 6. MdDone=1 in cycle 6.
- Back-to-back divu:
  - Stimulus: Op=10, RsData=100, RtData=7 in cycle 0, then a second divu held from cycle 1.
  - Required response: Stall=1 in cycles 1..10. Second MdStart in cycle 11, with Stall=0 that cycle.
- Divide by zero: Op=11, RtData=0 -> MdStart=0, DivZero=1 next cycle. State IDLE, so a subsequent mthi issues MdWe=1 immediately.
- mtlo with Hold/Flush:
  - MtValid=1, HiSel=0, RsData=0x1234, Hold=1 -> MdWe=0.
  - Next cycle with Hold=0 -> MdWe=1, MdHiLo=0, MdD1=0x1234.
  - Flush=1 in the same situation -> MdWe=0.
- Reset mid-op: Rst_n=0 asynchronously in cycle 3 of a div -> Stall and state clear at once. No MdDone after release, and a new mult is accepted in the first cycle after reset is released.
